// File: rtl/qpsk_demapper.sv
// rtl/qpsk_demapper.sv - hard-decision QPSK demapper packing sign bits of I/Q symbols into words
// and counting low-confidence components per word.
module qpsk_demapper #(
  parameter int DATA_WIDTH = 16,
  parameter int IQ_WIDTH = 16,
  parameter logic signed [IQ_WIDTH-1:0] WEAK_THRESHOLD = 16'sd4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              sym_valid,
  output logic                              sym_ready,
  input  logic [IQ_WIDTH-1:0]               sym_i,
  input  logic [IQ_WIDTH-1:0]               sym_q,
  output logic                              data_valid,
  input  logic                              data_ready,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic [$clog2(DATA_WIDTH+1)-1:0]   weak_count
);

  localparam int SYMS = DATA_WIDTH / 2;
  localparam int CW   = $clog2(DATA_WIDTH + 1);
  localparam int SCW  = (SYMS > 1) ? $clog2(SYMS) : 1;

  logic [SCW-1:0]        sym_cnt_q, sym_cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]         weak_acc_q, weak_acc_d;
  logic                  data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [CW-1:0]         weak_count_q, weak_count_d;

  logic                  last_sym;
  logic                  xfer;
  logic [IQ_WIDTH:0]     ext_i, ext_q, abs_i, abs_q, thr_ext;
  logic                  weak_i, weak_q;
  logic [CW-1:0]         weak_inc;
  logic [DATA_WIDTH-1:0] acc_upd;

  // Magnitude is taken one bit wider so the most negative sample stays large.
  always_comb begin
    ext_i   = {sym_i[IQ_WIDTH-1], sym_i};
    ext_q   = {sym_q[IQ_WIDTH-1], sym_q};
    abs_i   = sym_i[IQ_WIDTH-1] ? (~ext_i + {{IQ_WIDTH{1'b0}}, 1'b1}) : ext_i;
    abs_q   = sym_q[IQ_WIDTH-1] ? (~ext_q + {{IQ_WIDTH{1'b0}}, 1'b1}) : ext_q;
    thr_ext = {WEAK_THRESHOLD[IQ_WIDTH-1], WEAK_THRESHOLD};
    weak_i  = $signed(abs_i) < $signed(thr_ext);
    weak_q  = $signed(abs_q) < $signed(thr_ext);
    weak_inc = {{(CW-1){1'b0}}, weak_i} + {{(CW-1){1'b0}}, weak_q};
  end

  always_comb begin
    acc_upd = acc_q;
    for (int k = 0; k < SYMS; k++) begin
      if (sym_cnt_q == SCW'(k)) begin
        acc_upd[2*k]   = sym_i[IQ_WIDTH-1];
        acc_upd[2*k+1] = sym_q[IQ_WIDTH-1];
      end
    end
  end

  // Only the word-completing symbol waits for the output register to free up.
  always_comb begin
    last_sym  = (sym_cnt_q == SCW'(SYMS - 1));
    sym_ready = enable && !(last_sym && data_valid_q && !data_ready);
    xfer      = sym_valid && sym_ready;
  end

  always_comb begin
    sym_cnt_d    = sym_cnt_q;
    acc_d        = acc_q;
    weak_acc_d   = weak_acc_q;
    data_valid_d = data_valid_q;
    data_out_d   = data_out_q;
    weak_count_d = weak_count_q;

    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    if (xfer) begin
      if (last_sym) begin
        sym_cnt_d    = '0;
        acc_d        = '0;
        weak_acc_d   = '0;
        data_out_d   = acc_upd;
        weak_count_d = weak_acc_q + weak_inc;
        data_valid_d = 1'b1;
      end else begin
        sym_cnt_d  = sym_cnt_q + SCW'(1);
        acc_d      = acc_upd;
        weak_acc_d = weak_acc_q + weak_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt_q    <= '0;
      acc_q        <= '0;
      weak_acc_q   <= '0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
      weak_count_q <= '0;
    end else begin
      sym_cnt_q    <= sym_cnt_d;
      acc_q        <= acc_d;
      weak_acc_q   <= weak_acc_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
      weak_count_q <= weak_count_d;
    end
  end

  assign data_valid = data_valid_q;
  assign data_out   = data_out_q;
  assign weak_count = weak_count_q;

endmodule

// File: tb/tb_qpsk_demapper.sv
// tb/tb_qpsk_demapper.sv - self-checking bench for qpsk_demapper with a queue-based word model.
module tb_qpsk_demapper;

  localparam int SYMS = 8;
  localparam int THR  = 4096;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        sym_valid;
  logic        sym_ready;
  logic [15:0] sym_i;
  logic [15:0] sym_q;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] data_out;
  logic [4:0]  weak_count;

  int errors = 0;
  int checks = 0;

  // Reference model: symbols of the word being collected, plus the pending output word.
  int          mqi[$];
  int          mqq[$];
  logic        m_dv;
  logic [15:0] m_word;
  int          m_weak;

  qpsk_demapper #(.DATA_WIDTH(16), .IQ_WIDTH(16), .WEAK_THRESHOLD(16'sd4096)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_i      (sym_i),
    .sym_q      (sym_q),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_out   (data_out),
    .weak_count (weak_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mag(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_load();
    m_word = '0;
    m_weak = 0;
    for (int k = 0; k < SYMS; k++) begin
      if (mqi[k] < 0) m_word = m_word + 16'(1 << (2*k));
      if (mqq[k] < 0) m_word = m_word + 16'(1 << (2*k+1));
      if (mag(mqi[k]) < THR) m_weak++;
      if (mag(mqq[k]) < THR) m_weak++;
    end
    m_dv = 1'b1;
    mqi.delete();
    mqq.delete();
  endtask

  task automatic model_reset();
    mqi.delete();
    mqq.delete();
    m_dv = 1'b0;
    m_word = '0;
    m_weak = 0;
  endtask

  // One clock cycle: drive, check against model, advance model, clock.
  task automatic tick(input logic v, input logic [15:0] i, input logic [15:0] q,
                      input logic en, input logic dr, output logic acc);
    logic exp_ready;
    logic drain;
    logic loaded;
    sym_valid  = v;
    sym_i      = i;
    sym_q      = q;
    enable     = en;
    data_ready = dr;
    #1;
    exp_ready = en && !(mqi.size() == SYMS-1 && m_dv && !dr);
    chk("sym_ready", {31'd0, sym_ready}, {31'd0, exp_ready});
    chk("data_valid", {31'd0, data_valid}, {31'd0, m_dv});
    if (m_dv) begin
      chk("data_out", {16'd0, data_out}, {16'd0, m_word});
      chk("weak_count", {27'd0, weak_count}, 32'(m_weak));
    end
    acc    = v && exp_ready;
    drain  = m_dv && dr;
    loaded = 1'b0;
    if (acc) begin
      mqi.push_back(int'($signed(i)));
      mqq.push_back(int'($signed(q)));
      if (mqi.size() == SYMS) begin
        model_load();
        loaded = 1'b1;
      end
    end
    if (drain && !loaded) m_dv = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Hold a symbol until accepted, bounded.
  task automatic send(input logic [15:0] i, input logic [15:0] q, input logic dr);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      tick(1'b1, i, q, 1'b1, dr, acc);
      n++;
    end
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL send_timeout observed=0 expected=1");
    end
  endtask

  function automatic logic [15:0] rand_sample();
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0: return 16'($urandom);
      1: return ($urandom_range(0, 1) != 0) ? 16'(-(4095 + $urandom_range(0, 1)))
                                             : 16'(4095 + $urandom_range(0, 1));
      2: return ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
      default: return 16'h7fff;
    endcase
  endfunction

  logic [15:0] A;
  logic [15:0] NA;
  logic [15:0] si[8];
  logic [15:0] sq[8];
  logic [15:0] w_saved;
  logic        acc;

  initial begin
    A  = 16'sh5A82;
    NA = -A;
    rst = 1'b1;
    enable = 1'b1;
    sym_valid = 1'b0;
    sym_i = '0;
    sym_q = '0;
    data_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_data_valid", {31'd0, data_valid}, 32'd0);
    chk("reset_data_out", {16'd0, data_out}, 32'd0);
    chk("reset_weak_count", {27'd0, weak_count}, 32'd0);
    chk("reset_sym_ready", {31'd0, sym_ready}, 32'd1);
    rst = 1'b0;

    // Directed mapper-inverse word.
    send(NA, NA, 1'b1); send(A, A, 1'b1); send(A, A, 1'b1); send(NA, NA, 1'b1);
    send(NA, A, 1'b1);  send(NA, A, 1'b1); send(A, NA, 1'b1); send(A, NA, 1'b1);
    chk("dir_valid", {31'd0, data_valid}, 32'd1);
    chk("dir_word", {16'd0, data_out}, 32'h0000A5C3);
    chk("dir_weak", {27'd0, weak_count}, 32'd0);
    tick(1'b0, '0, '0, 1'b1, 1'b1, acc);
    chk("dir_pulse_end", {31'd0, data_valid}, 32'd0);

    // Zero and most-negative components.
    for (int k = 0; k < SYMS; k++) send(16'h0000, 16'h8000, 1'b1);
    chk("zero_word", {16'd0, data_out}, 32'h0000AAAA);
    chk("zero_weak", {27'd0, weak_count}, 32'd8);
    tick(1'b0, '0, '0, 1'b1, 1'b1, acc);

    // Backpressure: two words back to back with data_ready low.
    for (int k = 0; k < 15; k++) send(rand_sample(), rand_sample(), 1'b0);
    w_saved = m_word;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 16'h1234, 16'hF000, 1'b1, 1'b0, acc);
      chk("bp_stalled", {31'd0, acc}, 32'd0);
      chk("bp_hold", {16'd0, data_out}, {16'd0, w_saved});
    end
    tick(1'b1, 16'h1234, 16'hF000, 1'b1, 1'b1, acc);
    chk("bp_release_acc", {31'd0, acc}, 32'd1);
    chk("bp_valid_stays", {31'd0, data_valid}, 32'd1);
    tick(1'b0, '0, '0, 1'b1, 1'b1, acc);
    tick(1'b0, '0, '0, 1'b1, 1'b1, acc);

    // Enable gap mid-word must not change the result.
    for (int k = 0; k < SYMS; k++) begin
      si[k] = rand_sample();
      sq[k] = rand_sample();
    end
    for (int k = 0; k < SYMS; k++) send(si[k], sq[k], 1'b1);
    w_saved = m_word;
    tick(1'b0, '0, '0, 1'b1, 1'b1, acc);
    for (int k = 0; k < 3; k++) send(si[k], sq[k], 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, si[3], sq[3], 1'b0, 1'b1, acc);
      chk("en_gap_noxfer", {31'd0, acc}, 32'd0);
    end
    for (int k = 3; k < SYMS; k++) send(si[k], sq[k], 1'b1);
    chk("en_gap_word", {16'd0, data_out}, {16'd0, w_saved});
    tick(1'b0, '0, '0, 1'b1, 1'b1, acc);

    // Threshold boundary: three components at magnitude 4095.
    send(16'd4095, 16'hF000, 1'b1);
    send(16'hF001, 16'd4096, 1'b1);
    send(16'd4095, 16'd30000, 1'b1);
    for (int k = 3; k < SYMS; k++) send(16'd20000, 16'hB1E0, 1'b1);
    chk("thr_weak", {27'd0, weak_count}, 32'd3);
    tick(1'b0, '0, '0, 1'b1, 1'b1, acc);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      tick(1'($urandom_range(0, 3) != 0), rand_sample(), rand_sample(),
           1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0), acc);
    end
    for (int n = 0; n < 3; n++) tick(1'b0, '0, '0, 1'b1, 1'b1, acc);

    // Asynchronous reset mid-word, mid-cycle.
    for (int k = 0; k < 5; k++) send(NA, NA, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, data_valid}, 32'd0);
    chk("arst_data", {16'd0, data_out}, 32'd0);
    chk("arst_weak", {27'd0, weak_count}, 32'd0);
    chk("arst_ready", {31'd0, sym_ready}, 32'd1);
    model_reset();
    rst = 1'b0;
    send(NA, NA, 1'b1); send(A, A, 1'b1); send(A, A, 1'b1); send(NA, NA, 1'b1);
    send(NA, A, 1'b1);  send(NA, A, 1'b1); send(A, NA, 1'b1); send(A, NA, 1'b1);
    chk("arst_word", {16'd0, data_out}, 32'h0000A5C3);
    tick(1'b0, '0, '0, 1'b1, 1'b1, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
